// File: rtl/addsub8_arb.sv
// Two-requester arbiter sharing one 8-bit add/subtract datapath.
// Each operation takes IDLE -> EXEC -> DONE; ties are broken round-robin against the last grant.
module addsub8_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       add0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       add1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result,
    output logic       c_out,
    output logic       gnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic       opadd_q, opadd_d;
    logic       gnt_q, gnt_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic [7:0] result_q, result_d;
    logic       c_out_q, c_out_d;
    logic       busy_q, busy_d;
    logic       any_req_s;
    logic       win_s;
    logic [8:0] sum_s;

    // Subtract is A + ~B + 1, so bit 8 doubles as the "no borrow" flag.
    function automatic logic [8:0] addsub9(input logic [7:0] a, input logic [7:0] b,
                                           input logic add);
        addsub9 = {1'b0, a} + {1'b0, b ^ {8{~add}}} + {8'h00, ~add};
    endfunction

    assign sum_s = addsub9(opa_q, opb_q, opadd_q);

    // Winner selection: a lone request wins, a tie goes to the one not granted last.
    always_comb begin
        any_req_s = req0 | req1;
        if (req0 && req1) begin
            win_s = ~gnt_q;
        end else begin
            win_s = req1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, result update and next values of the registered outputs.
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        opadd_d  = opadd_q;
        gnt_d    = gnt_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    gnt_d = win_s;
                    if (win_s) begin
                        opa_d   = a1;
                        opb_d   = b1;
                        opadd_d = add1;
                    end else begin
                        opa_d   = a0;
                        opb_d   = b0;
                        opadd_d = add0;
                    end
                end else begin
                    gnt_d = gnt_q;
                end
            end
            ST_EXEC: begin
                result_d = sum_s[7:0];
                c_out_d  = sum_s[8];
            end
            ST_DONE: begin
                result_d = result_q;
            end
            default: begin
                result_d = result_q;
            end
        endcase
        // Done flops are loaded in EXEC so the pulse lines up with the DONE cycle.
        done0_d = (state_q == ST_EXEC) && !gnt_q;
        done1_d = (state_q == ST_EXEC) && gnt_q;
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; gnt resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opa_q    <= 8'h00;
            opb_q    <= 8'h00;
            opadd_q  <= 1'b0;
            gnt_q    <= 1'b1;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= 8'h00;
            c_out_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opadd_q  <= opadd_d;
            gnt_q    <= gnt_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            busy_q   <= busy_d;
        end
    end

    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign c_out  = c_out_q;
    assign gnt    = gnt_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_addsub8_arb.sv
// Self-checking bench for addsub8_arb: directed cases plus random traffic against
// a timestamp-based reference model (grant edge g -> done/result at edge g+1 after grant).
module tb_addsub8_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, add0 = 1'b0, req1 = 1'b0, add1 = 1'b0;
    logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
    logic       done0, done1, c_out, gnt, busy;
    logic [7:0] result;

    always #5 clk = ~clk;

    addsub8_arb dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .add0(add0),
        .req1(req1), .a1(a1), .b1(b1), .add1(add1),
        .done0(done0), .done1(done1), .result(result),
        .c_out(c_out), .gnt(gnt), .busy(busy)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         edge_n   = 0;
    int         g        = -100;
    int         next_arb = 0;
    logic       m_gnt    = 1'b1;
    logic [7:0] m_res    = 8'h00;
    logic       m_c      = 1'b0;
    logic [7:0] p_res    = 8'h00;
    logic       p_c      = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic set_in(input logic r0, input logic [7:0] xa0, input logic [7:0] xb0,
                          input logic ad0, input logic r1, input logic [7:0] xa1,
                          input logic [7:0] xb1, input logic ad1);
        req0 = r0; a0 = xa0; b0 = xb0; add0 = ad0;
        req1 = r1; a1 = xa1; b1 = xb1; add1 = ad1;
    endtask

    // Reference: arbitration rules and plain integer arithmetic, evaluated at each rising edge.
    task automatic model_step();
        int   a, b, s;
        logic w, op;
        edge_n++;
        if (!rst) begin
            if (edge_n >= next_arb && (req0 || req1)) begin
                if (req0 && req1) w = ~m_gnt;
                else              w = req1;
                a  = w ? int'(a1) : int'(a0);
                b  = w ? int'(b1) : int'(b0);
                op = w ? add1 : add0;
                if (op) begin
                    s = a + b;
                    p_c = (s > 255);
                end else begin
                    s = a - b;
                    p_c = (a >= b);
                end
                p_res    = s[7:0];
                g        = edge_n;
                next_arb = edge_n + 3;
                m_gnt    = w;
            end
            if (edge_n == g + 1) begin
                m_res = p_res;
                m_c   = p_c;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("busy",   32'(busy),   32'(edge_n == g || edge_n == g + 1));
        check_val("done0",  32'(done0),  32'(edge_n == g + 1 && m_gnt == 1'b0));
        check_val("done1",  32'(done1),  32'(edge_n == g + 1 && m_gnt == 1'b1));
        check_val("gnt",    32'(gnt),    32'(m_gnt));
        check_val("result", 32'(result), 32'(m_res));
        check_val("c_out",  32'(c_out),  32'(m_c));
        check_val("done_excl", 32'(done0 & done1), 32'd0);
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Called at a falling edge; reset takes effect asynchronously and is released two cycles later.
    task automatic apply_reset();
        rst      = 1'b1;
        m_gnt    = 1'b1;
        m_res    = 8'h00;
        m_c      = 1'b0;
        g        = -100;
        next_arb = 0;
        #1;
        check_val("rst_result", 32'(result), 32'h00);
        check_val("rst_c_out",  32'(c_out),  32'd0);
        check_val("rst_gnt",    32'(gnt),    32'd1);
        check_val("rst_busy",   32'(busy),   32'd0);
        check_val("rst_done",   32'({done0, done1}), 32'd0);
        run_cycle();
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic single_op(input logic who, input logic [7:0] a, input logic [7:0] b,
                             input logic op, input logic [7:0] exp_r, input logic exp_c,
                             input string tag);
        if (who) set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, a, b, op);
        else     set_in(1'b1, a, b, op, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cycle();
        check_val({tag, "_gnt"}, 32'(gnt), 32'(who));
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cycle();
        check_val({tag, "_done"}, 32'(who ? done1 : done0), 32'd1);
        check_val({tag, "_res"},  32'(result), 32'(exp_r));
        check_val({tag, "_c"},    32'(c_out),  32'(exp_c));
        run_cycle();
    endtask

    initial begin
        logic exp_alt;
        @(negedge clk);
        apply_reset();

        single_op(1'b0, 8'd5,   8'd3,   1'b1, 8'h08, 1'b0, "add");
        single_op(1'b1, 8'd3,   8'd5,   1'b0, 8'hFE, 1'b0, "sub_borrow");
        single_op(1'b1, 8'd5,   8'd3,   1'b0, 8'h02, 1'b1, "sub_ok");
        single_op(1'b0, 8'hFF,  8'h01,  1'b1, 8'h00, 1'b1, "wrap");

        // Operands and request change after grant must not disturb the operation.
        set_in(1'b1, 8'd10, 8'd20, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cycle();
        set_in(1'b0, 8'd99, 8'd20, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cycle();
        check_val("late_change_res", 32'(result), 32'h1E);
        run_cycle();

        // Reset while in EXEC: operation abandoned, no done pulse afterwards.
        set_in(1'b1, 8'd7, 8'd9, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        run_cycle();
        set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        apply_reset();
        for (int i = 0; i < 4; i++) run_cycle();

        // Contention held from reset release: grants must alternate starting with 0.
        set_in(1'b1, 8'h40, 8'h11, 1'b1, 1'b1, 8'h20, 8'h30, 1'b0);
        @(negedge clk);
        apply_reset();
        exp_alt = 1'b0;
        for (int i = 0; i < 13; i++) begin
            run_cycle();
            if (done0 || done1) begin
                check_val("alt_gnt", 32'(gnt), 32'(exp_alt));
                exp_alt = ~exp_alt;
            end
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom), 1'($urandom),
                   $urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 99) == 0) apply_reset();
            else run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
